// File: rtl/term_writer.sv
// ---------------------------------------------------------------------------
// term_writer
//   Character-stream front end for the memory-mapped text terminal. Accepts
//   one byte per valid/ready handshake, interprets printable and control
//   characters, keeps a cursor, and acts as bus master on the terminal
//   buffer port (single writes, full-screen clear, hardware scroll by
//   read-modify-write).
//
// Ports
//   clk        system clock (shared with the terminal buffer)
//   rst        synchronous reset, active low
//   in_valid   in_data holds a character
//   in_data    character byte
//   in_ready   a character can be accepted this cycle (IDLE only)
//   busy       clear or scroll sequence in progress
//   cur_row    cursor row, 0..ROWS-1
//   cur_col    cursor column, 0..COLS-1
//   mem_ena    terminal buffer access enable
//   mem_rw     `MEM_READ / `MEM_WRITE
//   mem_addr   linear index row*COLS+col
//   mem_wdata  {24'b0, char}
//   mem_rdata  buffer read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module term_writer #(
  parameter int          COLS  = 70,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic [4:0]       cur_row,
  output logic [6:0]       cur_col,
  output logic             mem_ena,
  output logic             mem_rw,
  output logic [`DATA_BUS] mem_addr,
  output logic [`DATA_BUS] mem_wdata,
  input  logic [`DATA_BUS] mem_rdata
);

  typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, CLR} state_t;

  localparam logic [4:0]  ROW_LAST      = 5'(ROWS - 1);
  localparam logic [6:0]  COL_LAST      = 7'(COLS - 1);
  localparam logic [6:0]  COLS7         = 7'(COLS);
  localparam logic [11:0] COLS12        = 12'(COLS);
  localparam logic [11:0] SCR_LAST      = 12'(COLS * (ROWS - 1) - 1);
  localparam logic [11:0] LAST_ROW_BASE = 12'(COLS * (ROWS - 1));
  localparam logic [11:0] CLR_LAST      = 12'(COLS * ROWS - 1);

  state_t      state, state_n;
  logic [4:0]  row_n;
  logic [6:0]  col_n;
  logic [11:0] idx, idx_n;          // sequence address for scroll/clear
  logic [7:0]  put_char, put_char_n;
  logic        put_adv, put_adv_n;  // PUT advances the column afterwards (not for BS)
  logic        clr_home, clr_home_n;// CLR homes the cursor at the end (FF, not scroll)
  logic        newline;
  logic [6:0]  tab_col;
  logic [11:0] cur_lin;

  // Only the character byte of the read data is moved during a scroll.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[31:8];

  assign cur_lin  = 12'(32'(cur_row) * 32'(COLS) + 32'(cur_col));
  assign tab_col  = (cur_col | 7'd7) + 7'd1;
  assign in_ready = (state == IDLE);
  assign busy     = (state == SCR_RD) || (state == SCR_WR) || (state == CLR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cur_row  <= '0;
      cur_col  <= '0;
      idx      <= '0;
      put_char <= '0;
      put_adv  <= 1'b0;
      clr_home <= 1'b0;
    end else begin
      state    <= state_n;
      cur_row  <= row_n;
      cur_col  <= col_n;
      idx      <= idx_n;
      put_char <= put_char_n;
      put_adv  <= put_adv_n;
      clr_home <= clr_home_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    state_n    = state;
    row_n      = cur_row;
    col_n      = cur_col;
    idx_n      = idx;
    put_char_n = put_char;
    put_adv_n  = put_adv;
    clr_home_n = clr_home;
    newline    = 1'b0;
    mem_ena    = 1'b0;
    mem_rw     = `MEM_READ;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            put_char_n = in_data;
            put_adv_n  = 1'b1;
            state_n    = PUT;
          end else begin
            case (in_data)
              8'h0A: newline = 1'b1;
              8'h0D: col_n = '0;
              8'h08: begin
                if (cur_col != '0) begin
                  col_n      = cur_col - 7'd1;
                  put_char_n = BLANK;
                  put_adv_n  = 1'b0;
                  state_n    = PUT;
                end
              end
              8'h09: begin
                if (tab_col >= COLS7) newline = 1'b1;
                else                  col_n   = tab_col;
              end
              8'h0C: begin
                idx_n      = '0;
                clr_home_n = 1'b1;
                state_n    = CLR;
              end
              default: ;
            endcase
          end
        end
      end

      PUT: begin
        mem_ena   = 1'b1;
        mem_rw    = `MEM_WRITE;
        mem_addr  = 32'(cur_lin);
        mem_wdata = {24'b0, put_char};
        state_n   = IDLE;
        if (put_adv) begin
          if (cur_col < COL_LAST) col_n   = cur_col + 7'd1;
          else                    newline = 1'b1;
        end
      end

      SCR_RD: begin
        mem_ena  = 1'b1;
        mem_rw   = `MEM_READ;
        mem_addr = 32'(idx + COLS12);
        state_n  = SCR_WR;
      end

      // The read issued in SCR_RD returns this cycle and is written one row up.
      SCR_WR: begin
        mem_ena   = 1'b1;
        mem_rw    = `MEM_WRITE;
        mem_addr  = 32'(idx);
        mem_wdata = {24'b0, mem_rdata[7:0]};
        if (idx == SCR_LAST) begin
          idx_n   = LAST_ROW_BASE;
          state_n = CLR;
        end else begin
          idx_n   = idx + 12'd1;
          state_n = SCR_RD;
        end
      end

      CLR: begin
        mem_ena   = 1'b1;
        mem_rw    = `MEM_WRITE;
        mem_addr  = 32'(idx);
        mem_wdata = {24'b0, BLANK};
        if (idx == CLR_LAST) begin
          state_n = IDLE;
          if (clr_home) begin
            row_n = '0;
            col_n = '0;
          end
        end else begin
          idx_n = idx + 12'd1;
        end
      end

      default: state_n = IDLE;
    endcase

    // Row advance shared by LF, TAB overflow and column wrap: at the bottom
    // row the cursor parks at column 0 and a scroll is started.
    if (newline) begin
      col_n = '0;
      if (cur_row < ROW_LAST) begin
        row_n = cur_row + 5'd1;
      end else begin
        row_n      = ROW_LAST;
        idx_n      = '0;
        clr_home_n = 1'b0;
        state_n    = SCR_RD;
      end
    end
  end

endmodule

// File: tb/tb_term_writer.sv
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module tb_term_writer;

  localparam int COLS = 70;
  localparam int ROWS = 30;
  localparam int CELLS = COLS * ROWS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready, busy;
  logic [4:0]       cur_row;
  logic [6:0]       cur_col;
  logic             mem_ena, mem_rw;
  logic [`DATA_BUS] mem_addr, mem_wdata;
  logic [`DATA_BUS] mem_rdata = '0;

  term_writer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .cur_row(cur_row), .cur_col(cur_col),
    .mem_ena(mem_ena), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #10 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int busy_cycles = 0;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] buf_mem[CELLS];  // terminal buffer model driven by the DUT
  logic [7:0] exp_mem[CELLS];  // expected buffer contents

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Terminal buffer: writes land at the edge, reads return the next cycle.
  // Upper read bits carry junk so only the character byte may be used.
  always @(posedge clk) begin
    if (mem_ena === 1'b1 && mem_addr < CELLS) begin
      if (mem_rw == `MEM_WRITE) buf_mem[mem_addr[11:0]] <= mem_wdata[7:0];
      else                      mem_rdata <= {24'hA5A5A5, buf_mem[mem_addr[11:0]]};
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (mem_ena === 1'b1 && mem_rw == `MEM_WRITE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, 32'(e.addr));
        check("wr_data", mem_wdata, {24'b0, e.data});
      end
    end
  end

  task automatic expect_wr(input int a, input logic [7:0] d);
    wr_t e;
    e.addr = 12'(a);
    e.data = d;
    exp_q.push_back(e);
    exp_mem[a] = d;
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("send_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic check_cursor(input string tag, input int r, input int c);
    check({tag, "_row"}, 32'(cur_row), 32'(r));
    check({tag, "_col"}, 32'(cur_col), 32'(c));
  endtask

  initial begin
    for (int i = 0; i < CELLS; i++) begin
      buf_mem[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_ena", 32'(mem_ena), 32'd0);
    check("rst_mem_rw", 32'(mem_rw), 32'(`MEM_READ));
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_cursor("rst", 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 'A','B': one write each, in_ready low for exactly one cycle
    expect_wr(0, 8'h41);
    send(8'h41);
    @(negedge clk);
    check("A_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("A_ready_back", 32'(in_ready), 32'd1);
    expect_wr(1, 8'h42);
    send(8'h42);
    @(negedge clk);
    check("B_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("B_ready_back", 32'(in_ready), 32'd1);
    check_cursor("AB", 0, 2);

    // CR then a full row of 'x'
    send(8'h0D);
    @(negedge clk);
    check_cursor("cr", 0, 0);
    check("cr_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < COLS; i++) begin
      expect_wr(i, 8'h78);
      send(8'h78);
    end
    wait_idle();
    check_cursor("row_x", 1, 0);
    check("row_x_busy", 32'(busy), 32'd0);

    // Backspace at column 0, then at column 10
    repeat (4) send(8'h0A);
    send(8'h08);
    @(negedge clk);
    check("bs0_ena", 32'(mem_ena), 32'd0);
    check_cursor("bs0", 5, 0);
    send(8'h09);
    @(negedge clk);
    check_cursor("tab_5_0", 5, 8);
    expect_wr(358, 8'h79);
    send(8'h79);
    expect_wr(359, 8'h79);
    send(8'h79);
    wait_idle();
    check_cursor("pre_bs", 5, 10);
    expect_wr(359, 8'h20);
    send(8'h08);
    wait_idle();
    check_cursor("bs", 5, 9);

    // Form feed: full clear
    for (int i = 0; i < CELLS; i++) expect_wr(i, 8'h20);
    busy_cycles = 0;
    send(8'h0C);
    wait_idle();
    check("ff_busy_cycles", 32'(busy_cycles), 32'(CELLS));
    check_cursor("ff", 0, 0);
    check("ff_sb_empty", 32'(exp_q.size()), 32'd0);

    // TAB stops and TAB overflow treated as LF
    expect_wr(0, 8'h61); send(8'h61);
    expect_wr(1, 8'h62); send(8'h62);
    expect_wr(2, 8'h63); send(8'h63);
    send(8'h09);
    wait_idle();
    check_cursor("tab_0_3", 0, 8);
    repeat (7) send(8'h09);
    expect_wr(64, 8'h71);
    send(8'h71);
    wait_idle();
    check_cursor("pre_tab65", 0, 65);
    send(8'h09);
    @(negedge clk);
    check_cursor("tab_0_65", 1, 0);
    check("tab_no_ena", 32'(mem_ena), 32'd0);

    // Scroll: row 1 full of 'B', cursor (29,3), LF
    for (int i = 0; i < COLS; i++) begin
      expect_wr(COLS + i, 8'h42);
      send(8'h42);
    end
    repeat (27) send(8'h0A);
    for (int i = 0; i < 3; i++) begin
      expect_wr(29 * COLS + i, 8'h63);
      send(8'h63);
    end
    wait_idle();
    check_cursor("pre_scroll", 29, 3);
    for (int i = 0; i < COLS * (ROWS - 1); i++) expect_wr(i, exp_mem[i + COLS]);
    for (int i = COLS * (ROWS - 1); i < CELLS; i++) expect_wr(i, 8'h20);
    busy_cycles = 0;
    send(8'h0A);
    wait_idle();
    check("scroll_busy_cycles", 32'(busy_cycles), 32'd4130);
    check_cursor("scroll", 29, 0);
    check("scroll_ready", 32'(in_ready), 32'd1);
    check("scroll_sb_empty", 32'(exp_q.size()), 32'd0);
    check("scroll_mem0", 32'(buf_mem[0]), 32'h42);
    check("scroll_mem69", 32'(buf_mem[69]), 32'h42);
    check("scroll_mem1960", 32'(buf_mem[1960]), 32'h63);
    check("scroll_mem2030", 32'(buf_mem[2030]), 32'h20);
    check("scroll_mem2099", 32'(buf_mem[2099]), 32'h20);

    // Form feed abandoned by reset after 50 writes
    for (int i = 0; i < 50; i++) expect_wr(i, 8'h20);
    send(8'h0C);
    repeat (50) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midclr_ena", 32'(mem_ena), 32'd0);
    check("midclr_busy", 32'(busy), 32'd0);
    check_cursor("midclr", 0, 0);
    check("midclr_sb_empty", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midclr_ready", 32'(in_ready), 32'd1);
    check("midclr_no_more", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
